// File: rtl/mult_err_pkg.sv
// rtl/mult_err_pkg.sv - shared FSM state type and width helpers for mult_err_monitor
package mult_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Product / error distance width
    function automatic int prod_w(input int n);
        return 2 * n;
    endfunction

    // Exact-match counter width: must hold 2^(2N)
    function automatic int cnt_w(input int n);
        return 2 * n + 1;
    endfunction

    // Error sum width: 2^(2N) terms of at most 2N bits
    function automatic int sum_w(input int n);
        return 4 * n;
    endfunction

    // Squared error sum width: 2^(2N) terms of at most 4N bits
    function automatic int sq_w(input int n);
        return 6 * n;
    endfunction

endpackage

// File: rtl/mult_err_acc.sv
// rtl/mult_err_acc.sv - error accumulators with one-cycle capture stage
// Optional squared-error sum enabled by MULT_ERR_SQ_EN.
module mult_err_acc
    import mult_err_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   cap_i,
    input  logic [N-1:0]           a_i,
    input  logic [N-1:0]           b_i,
    input  logic [prod_w(N)-1:0]   y_i,
    output logic [cnt_w(N)-1:0]    correct_cnt_o,
    output logic [sum_w(N)-1:0]    err_sum_o,
`ifdef MULT_ERR_SQ_EN
    output logic [sq_w(N)-1:0]     sq_err_sum_o,
`endif
    output logic [prod_w(N)-1:0]   max_err_o
);

    localparam int PW  = prod_w(N);
    localparam int CW  = cnt_w(N);
    localparam int SW  = sum_w(N);

    logic [PW-1:0] prod;
    logic [PW-1:0] diff;

    logic          vld_d, vld_q;
    logic          hit_d, hit_q;
    logic [PW-1:0] err_d, err_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [SW-1:0] sum_d, sum_q;
    logic [PW-1:0] max_d, max_q;
`ifdef MULT_ERR_SQ_EN
    localparam int QW = sq_w(N);
    logic [QW-1:0] sq_d, sq_q;
`endif

    // Stage 1 captures the error of the pair driven this cycle; stage 2 folds it in next cycle.
    always_comb begin
        prod  = PW'(a_i) * PW'(b_i);
        diff  = (prod >= y_i) ? (prod - y_i) : (y_i - prod);
        vld_d = cap_i;
        err_d = diff;
        hit_d = (diff == '0);
        cnt_d = cnt_q;
        sum_d = sum_q;
        max_d = max_q;
`ifdef MULT_ERR_SQ_EN
        sq_d  = sq_q;
`endif
        if (clr_i) begin
            vld_d = 1'b0;
            cnt_d = '0;
            sum_d = '0;
            max_d = '0;
`ifdef MULT_ERR_SQ_EN
            sq_d  = '0;
`endif
        end else if (vld_q) begin
            cnt_d = cnt_q + CW'(hit_q);
            sum_d = sum_q + SW'(err_q);
            if (err_q > max_q) begin
                max_d = err_q;
            end
`ifdef MULT_ERR_SQ_EN
            sq_d  = sq_q + QW'(err_q) * QW'(err_q);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            hit_q <= 1'b0;
            err_q <= '0;
            cnt_q <= '0;
            sum_q <= '0;
            max_q <= '0;
`ifdef MULT_ERR_SQ_EN
            sq_q  <= '0;
`endif
        end else begin
            vld_q <= vld_d;
            hit_q <= hit_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
            sum_q <= sum_d;
            max_q <= max_d;
`ifdef MULT_ERR_SQ_EN
            sq_q  <= sq_d;
`endif
        end
    end

    assign correct_cnt_o = cnt_q;
    assign err_sum_o     = sum_q;
    assign max_err_o     = max_q;
`ifdef MULT_ERR_SQ_EN
    assign sq_err_sum_o  = sq_q;
`endif

endmodule

// File: rtl/mult_err_monitor.sv
// rtl/mult_err_monitor.sv - exhaustive sweep FSM and operand counter for an external multiplier
// Optional sq_err_sum output enabled by MULT_ERR_SQ_EN.
module mult_err_monitor
    import mult_err_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [N-1:0]           a_out,
    output logic [N-1:0]           b_out,
    input  logic [prod_w(N)-1:0]   y_in,
    output logic                   busy,
    output logic                   done,
    output logic [cnt_w(N)-1:0]    correct_cnt,
    output logic [sum_w(N)-1:0]    err_sum,
`ifdef MULT_ERR_SQ_EN
    output logic [sq_w(N)-1:0]     sq_err_sum,
`endif
    output logic [prod_w(N)-1:0]   max_err
);

    localparam int PW = prod_w(N);

    state_t        state_d, state_q;
    logic [PW-1:0] cnt_d, cnt_q;
    logic          clr;
    logic          cap;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr     = 1'b0;
        cap     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            RUN: begin
                cap   = 1'b1;
                cnt_d = cnt_q + PW'(1);
                // Last pair is on the outputs; the counter wraps to zero on the way out.
                if (cnt_q == {PW{1'b1}}) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign a_out = cnt_q[PW-1:N];
    assign b_out = cnt_q[N-1:0];
    assign busy  = (state_q == RUN) || (state_q == DRAIN);
    assign done  = (state_q == DONE);

    mult_err_acc #(
        .N (N)
    ) u_acc (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr_i         (clr),
        .cap_i         (cap),
        .a_i           (a_out),
        .b_i           (b_out),
        .y_i           (y_in),
        .correct_cnt_o (correct_cnt),
        .err_sum_o     (err_sum),
`ifdef MULT_ERR_SQ_EN
        .sq_err_sum_o  (sq_err_sum),
`endif
        .max_err_o     (max_err)
    );

endmodule

// File: tb/tb_mult_err_monitor.sv
// tb/tb_mult_err_monitor.sv - self-checking bench for mult_err_monitor (N=4)
module tb_mult_err_monitor;

    localparam int N     = 4;
    localparam int PAIRS = 1 << (2 * N);
    localparam int LAT   = PAIRS + 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   a_out, b_out;
    logic [2*N-1:0] y_in;
    logic           busy, done;
    logic [2*N:0]   correct_cnt;
    logic [4*N-1:0] err_sum;
    logic [2*N-1:0] max_err;
`ifdef MULT_ERR_SQ_EN
    logic [6*N-1:0] sq_err_sum;
`endif

    int             mode;
    logic [2*N-1:0] rand_y [PAIRS];
    int             n_checks = 0;
    int             n_errors = 0;

    typedef struct {
        int     mode;
        int     exp_cnt;
        int     exp_sum;
        int     exp_max;
        longint exp_sq;
    } vec_t;

    vec_t vecs [3];

    mult_err_monitor #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a_out       (a_out),
        .b_out       (b_out),
        .y_in        (y_in),
        .busy        (busy),
        .done        (done),
        .correct_cnt (correct_cnt),
        .err_sum     (err_sum),
`ifdef MULT_ERR_SQ_EN
        .sq_err_sum  (sq_err_sum),
`endif
        .max_err     (max_err)
    );

    always #5 clk = ~clk;

    function automatic int y_of(input int m, input int a, input int b);
        case (m)
            0:       return a * b;
            1:       return 0;
            2:       return (a * b) & ~1;
            default: return int'(rand_y[a * (1 << N) + b]);
        endcase
    endfunction

    // Reference model of the external multiplier output
    always_comb begin
        y_in = (2*N)'(y_of(mode, int'(a_out), int'(b_out)));
    end

    // Reference statistics over every operand pair
    task automatic model(input int m, output int c, output int s, output int mx, output longint sq);
        c = 0; s = 0; mx = 0; sq = 0;
        for (int a = 0; a < (1 << N); a++) begin
            for (int b = 0; b < (1 << N); b++) begin
                int e;
                e = a * b - y_of(m, a, b);
                if (e < 0) e = -e;
                if (e == 0) c++;
                s  += e;
                sq += longint'(e) * e;
                if (e > mx) mx = e;
            end
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " busy"},  longint'(busy), 0);
        check({tag, " done"},  longint'(done), 0);
        check({tag, " a_out"}, longint'(a_out), 0);
        check({tag, " b_out"}, longint'(b_out), 0);
        check({tag, " cnt"},   longint'(correct_cnt), 0);
        check({tag, " sum"},   longint'(err_sum), 0);
        check({tag, " max"},   longint'(max_err), 0);
`ifdef MULT_ERR_SQ_EN
        check({tag, " sq"},    longint'(sq_err_sum), 0);
`endif
    endtask

    task automatic check_results(input string tag, input int c, input int s, input int mx, input longint sq);
        check({tag, " correct_cnt"}, longint'(correct_cnt), c);
        check({tag, " err_sum"},     longint'(err_sum), s);
        check({tag, " max_err"},     longint'(max_err), mx);
        check({tag, " busy_done"},   longint'(busy), 0);
`ifdef MULT_ERR_SQ_EN
        check({tag, " sq_err_sum"},  longint'(sq_err_sum), sq);
`endif
    endtask

    // Pulse start and count edges (including the accepting one) until done rises.
    task automatic run_sweep(input string tag, input int m, input int repulse_at,
                             input int rst_at, output int cycles);
        mode  = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " start busy"}, longint'(busy), 1);
        check({tag, " start done"}, longint'(done), 0);
        check({tag, " start cnt"},  longint'(correct_cnt), 0);
        check({tag, " start ab"},   longint'({a_out, b_out}), 0);
        cycles = 1;
        while (!done && cycles < 2 * LAT) begin
            if (cycles == repulse_at) start = 1'b1;
            if (cycles == rst_at) rst_n = 1'b0;
            @(posedge clk); #1;
            cycles++;
            start = 1'b0;
            if (!rst_n) begin
                check_zero({tag, " midreset"});
                rst_n = 1'b1;
                return;
            end
        end
        // Results must hold while idling in DONE
        repeat (3) @(posedge clk);
        #1;
        check({tag, " held done"}, longint'(done), 1);
    endtask

    initial begin
        int     cyc;
        int     c, s, mx;
        longint sq;

        vecs[0] = '{mode: 0, exp_cnt: 256, exp_sum: 0,     exp_max: 0,   exp_sq: 0};
        vecs[1] = '{mode: 1, exp_cnt: 31,  exp_sum: 14400, exp_max: 225, exp_sq: 1537600};
        vecs[2] = '{mode: 2, exp_cnt: 192, exp_sum: 64,    exp_max: 1,   exp_sq: 64};

        mode  = 0;
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        check_zero("start_during_reset");

        for (int i = 0; i < 3; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_sweep(tag, vecs[i].mode, -1, -1, cyc);
            check({tag, " latency"}, cyc, LAT);
            check_results(tag, vecs[i].exp_cnt, vecs[i].exp_sum, vecs[i].exp_max, vecs[i].exp_sq);
        end

        for (int r = 0; r < 3; r++) begin
            string tag;
            tag = $sformatf("rand%0d", r);
            for (int k = 0; k < PAIRS; k++) begin
                int a, b;
                a = k >> N;
                b = k % (1 << N);
                rand_y[k] = ($urandom_range(0, 1) == 1) ? (2*N)'(a * b) : (2*N)'($urandom_range(0, PAIRS - 1));
            end
            model(3, c, s, mx, sq);
            run_sweep(tag, 3, -1, -1, cyc);
            check({tag, " latency"}, cyc, LAT);
            check_results(tag, c, s, mx, sq);
        end

        run_sweep("repulse", 0, 50, -1, cyc);
        check("repulse latency", cyc, LAT);
        check_results("repulse", 256, 0, 0, 0);

        run_sweep("abort", 1, -1, 100, cyc);
        @(posedge clk); #1;
        check_zero("after_abort_idle");
        run_sweep("post_abort", 0, -1, -1, cyc);
        check("post_abort latency", cyc, LAT);
        check_results("post_abort", 256, 0, 0, 0);

        run_sweep("restart", 2, -1, -1, cyc);
        check("restart latency", cyc, LAT);
        check_results("restart", 192, 64, 1, 64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
